multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 200 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Optional ILLEGAL_TRAP_EN: unrecognised opcodes park in a sticky ERROR state instead of being skipped.
module multicycle_controller #(
    parameter int width = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic [3:0] state_o
);

    if (width < 1) begin : g_width_check
        $error("multicycle_controller: width must be positive");
    end

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10,
        ERROR    = 4'd11
    } state_t;

    state_t     state, state_next;
    logic       illegal_op;
    logic [2:0] alu_funct;

    assign state_o = state;

    always_comb begin
        illegal_op = 1'b0;
        case (op)
            7'b0000011, 7'b0100011, 7'b0110011,
            7'b0010011, 7'b1101111, 7'b1100011: illegal_op = 1'b0;
            default:                            illegal_op = 1'b1;
        endcase
    end

    // Only R-type (op[5]=1) may turn funct3=000 into a subtract.
    always_comb begin
        alu_funct = 3'b000;
        case (funct3)
            3'b000:  alu_funct = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_funct = 3'b101;
            3'b110:  alu_funct = 3'b011;
            3'b111:  alu_funct = 3'b010;
            default: alu_funct = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:    state_next = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_next = MEMADR;
                    7'b0110011:             state_next = EXECUTER;
                    7'b0010011:             state_next = EXECUTEI;
                    7'b1101111:             state_next = JAL;
                    7'b1100011:             state_next = BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:                state_next = ERROR;
`else
                    default:                state_next = FETCH;
`endif
                endcase
            end
            MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            JAL:      state_next = ALUWB;
            BEQ:      state_next = FETCH;
`ifdef ILLEGAL_TRAP_EN
            ERROR:    state_next = ERROR;
`endif
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        case (op)
            7'b0100011: imm_src = 2'b01;
            7'b1100011: imm_src = 2'b10;
            7'b1101111: imm_src = 2'b11;
            default:    imm_src = 2'b00;
        endcase
        case (state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
`ifndef ILLEGAL_TRAP_EN
                instr_done = illegal_op;
`endif
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
            end
            EXECUTER: begin
                alu_src_a   = 2'b10;
                alu_control = alu_funct;
            end
            EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_funct;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                pc_write    = zero;
                instr_done  = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            ERROR:    illegal = 1'b1;
`endif
            default: ;
        endcase
        // Reset overrides any pending access so nothing is committed mid-instruction.
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-instruction expected state paths plus a per-state control table.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_controller #(.width(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .instr_done(instr_done), .illegal(illegal), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                   S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_JAL = 9,
                   S_BEQ = 10, S_ERROR = 11;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Static datapath routing per state: {adr_src, result_src, alu_src_a, alu_src_b, alu kind}
    // alu kind: 0 = add, 1 = sub, 2 = from funct fields
    localparam logic [8:0] ROUTE [12] = '{
        {1'b0, 2'b10, 2'b00, 2'b10, 2'd0},  // FETCH
        {1'b0, 2'b00, 2'b01, 2'b01, 2'd0},  // DECODE
        {1'b0, 2'b00, 2'b10, 2'b01, 2'd0},  // MEMADR
        {1'b1, 2'b00, 2'b00, 2'b00, 2'd0},  // MEMREAD
        {1'b0, 2'b01, 2'b00, 2'b00, 2'd0},  // MEMWB
        {1'b1, 2'b00, 2'b00, 2'b00, 2'd0},  // MEMWRITE
        {1'b0, 2'b00, 2'b10, 2'b00, 2'd2},  // EXECUTER
        {1'b0, 2'b00, 2'b10, 2'b01, 2'd2},  // EXECUTEI
        {1'b0, 2'b00, 2'b00, 2'b00, 2'd0},  // ALUWB
        {1'b0, 2'b00, 2'b01, 2'b10, 2'd0},  // JAL
        {1'b0, 2'b00, 2'b10, 2'b00, 2'd1},  // BEQ
        {1'b0, 2'b00, 2'b00, 2'b00, 2'd0}   // ERROR
    };

    function automatic bit is_legal(input logic [6:0] o);
        return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
               (o == OP_JAL) || (o == OP_BEQ);
    endfunction

    // Expected outputs packed as {pc_write, adr_src, mem_write, ir_write, reg_write, instr_done,
    // illegal, result_src, alu_src_a, alu_src_b, imm_src, alu_control}
    function automatic logic [17:0] model(input int st, input logic rs, input logic mr,
                                          input logic z, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7);
        logic [8:0] r;
        logic       pcw, irw, memw, regw, done, ill;
        logic [1:0] imm;
        logic [2:0] alu;
        r    = ROUTE[st];
        pcw  = (st == S_FETCH && mr) || st == S_JAL || (st == S_BEQ && z);
        irw  = (st == S_FETCH && mr);
        memw = (st == S_MEMWRITE);
        regw = (st == S_MEMWB) || (st == S_ALUWB);
        done = st == S_MEMWB || st == S_ALUWB || st == S_BEQ || (st == S_MEMWRITE && mr) ||
               (st == S_DECODE && !is_legal(o) && !TRAP);
        ill  = TRAP && st == S_ERROR;
        if (rs) {pcw, irw, memw, regw, done, ill} = '0;
        if (o == OP_SW)       imm = 2'b01;
        else if (o == OP_BEQ) imm = 2'b10;
        else if (o == OP_JAL) imm = 2'b11;
        else                  imm = 2'b00;
        if (r[1:0] == 2'd1)      alu = 3'b001;
        else if (r[1:0] == 2'd0) alu = 3'b000;
        else if (f3 == 3'b000)   alu = (o[5] && f7) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010)   alu = 3'b101;
        else if (f3 == 3'b110)   alu = 3'b011;
        else if (f3 == 3'b111)   alu = 3'b010;
        else                     alu = 3'b000;
        return {pcw, r[8], memw, irw, regw, done, ill, r[7:2], imm, alu};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks one cycle at the falling edge, then advances past the next rising edge.
    task automatic step(input int st, input string tag);
        logic [17:0] obs;
        @(negedge clk);
        obs = {pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control};
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_ctrl"}, 32'(obs), 32'(model(st, rst, mem_ready, zero, op, funct3, funct7b5)));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int fw, input int mw);
        int path[$];
        bit mrq[$];
        for (int k = 0; k < fw; k++) begin path.push_back(S_FETCH); mrq.push_back(1'b0); end
        path.push_back(S_FETCH);  mrq.push_back(1'b1);
        path.push_back(S_DECODE); mrq.push_back(1'($urandom_range(0, 1)));
        if (o == OP_LW || o == OP_SW) begin
            path.push_back(S_MEMADR); mrq.push_back(1'($urandom_range(0, 1)));
            for (int k = 0; k <= mw; k++) begin
                path.push_back(o == OP_LW ? S_MEMREAD : S_MEMWRITE);
                mrq.push_back(k == mw);
            end
            if (o == OP_LW) begin path.push_back(S_MEMWB); mrq.push_back(1'($urandom_range(0, 1))); end
        end else if (o == OP_R || o == OP_I || o == OP_JAL) begin
            path.push_back(o == OP_R ? S_EXECR : (o == OP_I ? S_EXECI : S_JAL));
            mrq.push_back(1'($urandom_range(0, 1)));
            path.push_back(S_ALUWB); mrq.push_back(1'($urandom_range(0, 1)));
        end else if (o == OP_BEQ) begin
            path.push_back(S_BEQ); mrq.push_back(1'($urandom_range(0, 1)));
        end else if (TRAP) begin
            path.push_back(S_ERROR); mrq.push_back(1'b1);
            path.push_back(S_ERROR); mrq.push_back(1'b0);
        end
        op = o; funct3 = f3; funct7b5 = f7; zero = z; rst = 1'b0;
        foreach (path[i]) begin
            mem_ready = mrq[i];
            step(path[i], $sformatf("%s_c%0d", name, i));
        end
        if (!is_legal(o) && TRAP) begin
            rst = 1'b1;
            step(S_ERROR, {name, "_rst"});
            rst = 1'b0;
        end
    endtask

    initial begin
        logic [6:0] bad_ops [5];
        bad_ops = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b1100111, 7'b0001111};
        rst = 1'b1; op = OP_LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(S_FETCH, "reset0");
        check("reset_irw", 32'(ir_write), 32'd0);
        step(S_FETCH, "reset1");
        rst = 1'b0;

        run_instr("lw",      OP_LW,  3'b010, 1'b0, 1'b0, 0, 0);
        run_instr("sw_wait", OP_SW,  3'b010, 1'b0, 1'b0, 1, 3);
        run_instr("r_sub",   OP_R,   3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("i_add",   OP_I,   3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("r_or",    OP_R,   3'b110, 1'b0, 1'b0, 0, 0);
        run_instr("i_slt",   OP_I,   3'b010, 1'b0, 1'b0, 0, 0);
        run_instr("beq_t",   OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("beq_nt",  OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("jal",     OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("ill",     7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);

        // Reset while a load waits on memory.
        op = OP_LW; mem_ready = 1'b1; step(S_FETCH, "rr_f");
        step(S_DECODE, "rr_d"); step(S_MEMADR, "rr_a");
        mem_ready = 1'b0; step(S_MEMREAD, "rr_w");
        rst = 1'b1; mem_ready = 1'b1; step(S_MEMREAD, "rr_rst");
        rst = 1'b0; mem_ready = 1'b0; step(S_FETCH, "rr_after");

        // Reset while a store holds mem_write and memory answers in the same cycle.
        op = OP_SW; mem_ready = 1'b1; step(S_FETCH, "rw_f");
        step(S_DECODE, "rw_d"); step(S_MEMADR, "rw_a");
        mem_ready = 1'b0; step(S_MEMWRITE, "rw_w");
        rst = 1'b1; mem_ready = 1'b1; step(S_MEMWRITE, "rw_rst");
        rst = 1'b0; mem_ready = 1'b0; step(S_FETCH, "rw_after");

        for (int n = 0; n < 60; n++) begin
            int cls;
            logic [6:0] o;
            cls = $urandom_range(0, 6);
            case (cls)
                0: o = OP_LW;  1: o = OP_SW;  2: o = OP_R;  3: o = OP_I;
                4: o = OP_JAL; 5: o = OP_BEQ; default: o = bad_ops[$urandom_range(0, 4)];
            endcase
            run_instr($sformatf("rnd%0d", n), o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
